// File: rtl/pwm_multich_if.sv
// pwm_multich_if: configuration port for the multi-channel PWM generator.
//
// A valid/ready write channel that carries a channel index and a duty value,
// plus a one-cycle error pulse for writes aimed at a channel that does not exist.
//
//   cfg_valid  master -> slave  write request
//   cfg_ch     master -> slave  target channel index (3 bits)
//   cfg_duty   master -> slave  requested duty in ticks (RES+1 bits)
//   cfg_ready  slave -> master  write accepted when high together with cfg_valid
//   cfg_err    slave -> master  one-cycle pulse: accepted write had a bad index
interface pwm_multich_if #(
  parameter int RES = 7
);
  logic           cfg_valid;
  logic           cfg_ready;
  logic [2:0]     cfg_ch;
  logic [RES:0]   cfg_duty;
  logic           cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_duty,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_duty,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/pwm_multich.sv
// pwm_multich: N-channel PWM generator with a shared prescaler and period counter.
//
// Each channel compares the shared period counter against its own threshold.
// Duty writes land in a per-channel shadow (pending) register and are copied
// into the active register only at the period boundary, so an output never
// changes shape mid-period. The direct/servo mode request is committed at the
// same boundary; servo mode uses a slower tick and maps duty onto a narrow
// threshold window.
//
//   clk           system clock
//   rst_n         asynchronous reset, active high despite the name
//   ena           run enable; when low, counters hold and outputs go low
//   mode_sel      requested mode: 0 = direct, 1 = servo
//   cfg           configuration write port (slave side)
//   pwm_out       registered PWM outputs, one bit per channel
//   period_start  one-cycle pulse after each period commit
module pwm_multich #(
  parameter int CHANNELS   = 3,
  parameter int RES        = 7,
  parameter int DIV_FAST   = 10416,
  parameter int DIV_SLOW   = 200000,
  parameter int SERVO_MIN  = 5,
  parameter int SERVO_SPAN = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                mode_sel,
  pwm_multich_if.slave        cfg,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  // Duty value that means full-on: exactly 2^RES.
  localparam logic [RES:0]   FULL  = {1'b1, {RES{1'b0}}};
  localparam logic [RES-1:0] D_MAX = '1;

  logic [31:0]         q_q, q_d;
  logic [RES-1:0]      d_q, d_d;
  logic                mode_q, mode_d;
  logic [RES:0]        pending_q [CHANNELS];
  logic [RES:0]        pending_d [CHANNELS];
  logic [RES:0]        active_q  [CHANNELS];
  logic [RES:0]        active_d  [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_start_q, period_start_d;
  logic                cfg_err_q, cfg_err_d;

  logic [31:0]         div;
  logic                tick;
  logic                boundary;
  logic                wr_en;
  logic                ch_ok;
  logic [RES:0]        duty_sat;
  logic [31:0]         thr_wide [CHANNELS];
  logic [RES:0]        thr      [CHANNELS];

  // Tick and boundary decode. The boundary is the last tick of the period;
  // config writes are refused in that cycle so a commit never races a write.
  always_comb begin
    div      = mode_q ? 32'(DIV_SLOW) : 32'(DIV_FAST);
    tick     = ena && (q_q == (div - 32'd1));
    boundary = tick && (d_q == D_MAX);
    wr_en    = cfg.cfg_valid && !boundary;
    ch_ok    = ({29'd0, cfg.cfg_ch} < 32'(CHANNELS));
    duty_sat = (cfg.cfg_duty > FULL) ? FULL : cfg.cfg_duty;
  end

  assign cfg.cfg_ready = !boundary;

  // Per-channel threshold from the committed duty and mode. Servo thresholds
  // can exceed 2^RES with large SERVO_MIN/SPAN, so clamp to FULL, which keeps
  // the "always high" meaning inside an RES+1 bit compare.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (mode_q) begin
        thr_wide[i] = 32'(SERVO_MIN) +
                      ((32'(active_q[i]) * 32'(SERVO_SPAN)) >> RES);
      end else begin
        thr_wide[i] = 32'(active_q[i]);
      end
      thr[i] = (thr_wide[i] > 32'(FULL)) ? FULL : thr_wide[i][RES:0];
    end
  end

  // Next-state logic for counters, shadow/active duties, mode and outputs.
  // The commit reads pending_q, which already holds any write accepted in the
  // cycle before the boundary.
  always_comb begin
    q_d            = q_q;
    d_d            = d_q;
    mode_d         = mode_q;
    pending_d      = pending_q;
    active_d       = active_q;
    period_start_d = boundary;
    cfg_err_d      = wr_en && !ch_ok;

    if (tick) begin
      q_d = '0;
      d_d = d_q + 1'b1;
    end else if (ena) begin
      q_d = q_q + 32'd1;
    end

    if (boundary) begin
      active_d = pending_q;
      mode_d   = mode_sel;
    end

    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_en && ch_ok && ({29'd0, cfg.cfg_ch} == 32'(i))) begin
        pending_d[i] = duty_sat;
      end
      pwm_d[i] = ena && ({1'b0, d_q} < thr[i]);
    end
  end

  // State registers; reset clears everything including uncommitted writes.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      q_q            <= '0;
      d_q            <= '0;
      mode_q         <= 1'b0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      cfg_err_q      <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        pending_q[i] <= '0;
        active_q[i]  <= '0;
      end
    end else begin
      q_q            <= q_d;
      d_q            <= d_d;
      mode_q         <= mode_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      cfg_err_q      <= cfg_err_d;
      for (int i = 0; i < CHANNELS; i++) begin
        pending_q[i] <= pending_d[i];
        active_q[i]  <= active_d[i];
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign cfg.cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_pwm_multich.sv
// tb_pwm_multich: self-checking bench for pwm_multich.
//
// A behavioural model tracks the position inside the current period as a
// count of enabled clocks, plus pending/active duty arrays and the mode.
// Every cycle the DUT outputs are compared with the model; directed steps
// additionally compare per-period high-time counts against fixed numbers.
module tb_pwm_multich;

  localparam int CH    = 3;
  localparam int RES   = 3;
  localparam int DIVF  = 4;
  localparam int DIVS  = 8;
  localparam int SMIN  = 2;
  localparam int SSPAN = 4;
  localparam int TICKS = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          mode_sel;
  logic [CH-1:0] pwm_out;
  logic          period_start;

  pwm_multich_if #(.RES(RES)) cfg ();

  pwm_multich #(
    .CHANNELS   (CH),
    .RES        (RES),
    .DIV_FAST   (DIVF),
    .DIV_SLOW   (DIVS),
    .SERVO_MIN  (SMIN),
    .SERVO_SPAN (SSPAN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .mode_sel     (mode_sel),
    .cfg          (cfg),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state.
  int            m_pos;
  int            m_mode;
  int            m_pend [CH];
  int            m_act  [CH];
  logic [CH-1:0] e_pwm;
  logic          e_ps;
  logic          e_err;

  // Observation counters for directed checks.
  int   hi [CH];
  int   ps_cnt;
  int   ps_last;
  int   err_cnt;
  int   cyc;
  logic obs_ready;
  int   hs_waits;

  function automatic int model_thr(input int duty, input int mode);
    if (mode != 0) return SMIN + (duty * SSPAN) / TICKS;
    return duty;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_pos  = 0;
    m_mode = 0;
    for (int i = 0; i < CH; i++) begin
      m_pend[i] = 0;
      m_act[i]  = 0;
    end
    e_pwm = '0;
    e_ps  = 1'b0;
    e_err = 1'b0;
  endtask

  task automatic clearCounts();
    for (int i = 0; i < CH; i++) hi[i] = 0;
    ps_cnt  = 0;
    ps_last = -1;
    err_cnt = 0;
    cyc     = 0;
  endtask

  // One clock: drive inputs at the falling edge, predict the cycle from the
  // model, then compare the registered outputs just after the rising edge.
  task automatic applyStimulus(input logic v, input int ch, input int duty);
    int   div;
    logic bnd;
    logic rdy;
    @(negedge clk);
    cfg.cfg_valid = v;
    cfg.cfg_ch    = 3'(ch);
    cfg.cfg_duty  = 4'(duty);
    div = (m_mode != 0) ? DIVS : DIVF;
    bnd = ena && (m_pos == div * TICKS - 1);
    rdy = !bnd;
    #1;
    obs_ready = cfg.cfg_ready;
    checkOutput("cfg_ready", 32'(cfg.cfg_ready), 32'(rdy));
    @(posedge clk);
    for (int i = 0; i < CH; i++)
      e_pwm[i] = ena && ((m_pos / div) < model_thr(m_act[i], m_mode));
    e_ps  = bnd;
    e_err = v && rdy && (ch >= CH);
    if (v && rdy && ch < CH) m_pend[ch] = (duty > TICKS) ? TICKS : duty;
    if (bnd) begin
      for (int i = 0; i < CH; i++) m_act[i] = m_pend[i];
      m_mode = int'(mode_sel);
      m_pos  = 0;
    end else if (ena) begin
      m_pos++;
    end
    #1;
    checkOutput("pwm_out", 32'(pwm_out), 32'(e_pwm));
    checkOutput("period_start", 32'(period_start), 32'(e_ps));
    checkOutput("cfg_err", 32'(cfg.cfg_err), 32'(e_err));
    for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
    if (period_start) begin
      ps_cnt++;
      ps_last = cyc;
    end
    err_cnt += int'(cfg.cfg_err);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 0, 0);
  endtask

  // Runs until the DUT shows period_start, bounded; ps_last gives the cycle.
  task automatic waitBoundary();
    clearCounts();
    for (int k = 0; k < 300 && ps_cnt == 0; k++) idle(1);
    checkOutput("boundary_seen", 32'(ps_cnt), 32'd1);
  endtask

  initial begin
    rst_n         = 1'b1;
    ena           = 1'b1;
    mode_sel      = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch    = '0;
    cfg.cfg_duty  = '0;
    modelReset();
    clearCounts();

    // Reset state.
    #1;
    checkOutput("rst_pwm_out", 32'(pwm_out), 32'd0);
    checkOutput("rst_period_start", 32'(period_start), 32'd0);
    checkOutput("rst_cfg_err", 32'(cfg.cfg_err), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;

    // Basic duty: 3 -> 12 clk high, 8 -> always high, 0 -> always low.
    applyStimulus(1'b1, 0, 3);
    applyStimulus(1'b1, 1, 8);
    applyStimulus(1'b1, 2, 0);
    waitBoundary();
    clearCounts();
    idle(32);
    checkOutput("basic_hi0", 32'(hi[0]), 32'd12);
    checkOutput("basic_hi1", 32'(hi[1]), 32'd32);
    checkOutput("basic_hi2", 32'(hi[2]), 32'd0);
    checkOutput("basic_ps_cnt", 32'(ps_cnt), 32'd1);
    checkOutput("basic_ps_last", 32'(ps_last), 32'd31);

    // Shadow commit: active 2, then write 6 at d = 2.
    applyStimulus(1'b1, 0, 2);
    waitBoundary();
    clearCounts();
    idle(8);
    applyStimulus(1'b1, 0, 6);
    idle(23);
    checkOutput("shadow_cur_hi0", 32'(hi[0]), 32'd8);
    checkOutput("shadow_cur_ps", 32'(ps_last), 32'd31);
    clearCounts();
    idle(32);
    checkOutput("shadow_next_hi0", 32'(hi[0]), 32'd24);

    // Handshake held across the boundary: refused once, accepted next cycle.
    idle(31);
    hs_waits = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1, 5);
      if (obs_ready) break;
      hs_waits++;
    end
    checkOutput("hs_waits", 32'(hs_waits), 32'd1);
    clearCounts();
    applyStimulus(1'b1, 5, 3);
    idle(2);
    checkOutput("bad_ch_err_cnt", 32'(err_cnt), 32'd1);
    applyStimulus(1'b1, 2, 15);
    waitBoundary();
    clearCounts();
    idle(32);
    checkOutput("sat_hi2", 32'(hi[2]), 32'd32);
    checkOutput("hs_hi1", 32'(hi[1]), 32'd20);
    checkOutput("bad_ch_hi0", 32'(hi[0]), 32'd24);

    // Mode switch requested at d = 4 takes effect at the boundary.
    applyStimulus(1'b1, 0, 4);
    applyStimulus(1'b1, 1, 0);
    waitBoundary();
    clearCounts();
    idle(16);
    mode_sel = 1'b1;
    idle(16);
    checkOutput("mode_direct_hi0", 32'(hi[0]), 32'd16);
    checkOutput("mode_direct_ps", 32'(ps_last), 32'd31);
    clearCounts();
    idle(64);
    checkOutput("servo_hi0", 32'(hi[0]), 32'd32);
    checkOutput("servo_hi1", 32'(hi[1]), 32'd16);
    checkOutput("servo_ps_cnt", 32'(ps_cnt), 32'd1);
    checkOutput("servo_ps_last", 32'(ps_last), 32'd63);
    mode_sel = 1'b0;
    waitBoundary();

    // Enable gating at d = 1 for 10 clk, with a write while disabled.
    idle(4);
    ena = 1'b0;
    clearCounts();
    applyStimulus(1'b1, 0, 2);
    idle(9);
    checkOutput("ena_off_hi2", 32'(hi[2]), 32'd0);
    checkOutput("ena_off_hi0", 32'(hi[0]), 32'd0);
    ena = 1'b1;
    waitBoundary();
    checkOutput("ena_resume_len", 32'(ps_last), 32'd27);
    clearCounts();
    idle(32);
    checkOutput("ena_commit_hi0", 32'(hi[0]), 32'd8);

    // Randomized traffic against the model.
    for (int k = 0; k < 500; k++) begin
      ena      = ($urandom_range(0, 9) != 0);
      mode_sel = 1'($urandom_range(0, 1));
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 15)));
    end
    ena      = 1'b1;
    mode_sel = 1'b0;

    // Async reset mid-period: outputs clear without a clock edge.
    applyStimulus(1'b1, 2, 8);
    waitBoundary();
    idle(10);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("async_pwm_out", 32'(pwm_out), 32'd0);
    checkOutput("async_period_start", 32'(period_start), 32'd0);
    checkOutput("async_cfg_err", 32'(cfg.cfg_err), 32'd0);
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    waitBoundary();
    checkOutput("post_rst_first_ps", 32'(ps_last), 32'd31);
    clearCounts();
    idle(32);
    checkOutput("post_rst_hi0", 32'(hi[0]), 32'd0);
    checkOutput("post_rst_hi1", 32'(hi[1]), 32'd0);
    checkOutput("post_rst_hi2", 32'(hi[2]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
